fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
- Parametrised single-clock FIFO; the next generation of the team's extra-MSB-pointer synchronous FIFO.
- Adds:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - occupancy count
  - programmable almost-full and almost-empty flags
  - overflow and underflow error pulses
- Sits between producer/consumer datapaths inside one clock domain; no CDC.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- FWFT, 0, read mode. 0 = standard registered read. 1 = first-word-fall-through.
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- w_en  input  1  write request.
- in_data  input  WIDTH  write data.
- r_en  input  1  read request (in FWFT mode: acknowledge/pop of the head word).
- out_data  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Pointers:
  - w_ptr and r_ptr are PW+1 bits, where PW = $clog2(DEPTH).
  - Low PW bits address memory; the MSB toggles on wrap.
  - full = MSBs differ and low bits equal.
  - empty = pointers fully equal.
  - count = w_ptr - r_ptr, modulo 2^(PW+1).
- Reset (rst low, async): w_ptr = 0, r_ptr = 0, out_data = 0, overflow = 0, underflow = 0. Outputs then read empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0. Memory contents are not cleared.
- Reset mid-operation discards all stored words immediately; flags reflect empty in the same cycle reset asserts.
- Write accept = w_en & !full. The word is stored at mem[w_ptr] and w_ptr increments at the clock edge.
- Read accept = r_en & !empty. r_ptr increments at the clock edge.
- Standard mode (FWFT=0):
  - out_data is registered and loads mem[r_ptr] on an accepted read, i.e. 1-cycle latency from the r_en edge.
  - Otherwise out_data holds its value.
- FWFT mode (FWFT=1):
  - out_data = mem[r_ptr] combinationally while !empty; 0 while empty.
  - A word written into an empty FIFO is visible on out_data the cycle after its write edge, together with empty deasserting.
  - r_en pops it; the next word appears the following cycle.
- Simultaneous write and read:
  - When 0 < count < DEPTH: both accepted, count unchanged.
  - When full: read accepted, write rejected; overflow pulses.
  - When empty: write accepted, read rejected; underflow pulses.
- Error pulses:
  - overflow is registered to 1 for exactly one cycle after an edge where w_en & full.
  - underflow is registered to 1 for exactly one cycle after an edge where r_en & empty.
  - Rejected operations leave pointers and memory untouched.
- Flags full, empty, almost_*, and count are combinational from the registered pointers, so they update the cycle after the causing edge.
- Pointer wrap: continuous streaming through 2*DEPTH+1 words must keep count and flags correct across both MSB toggles.
- Illegal parameters (non-power-of-two DEPTH, thresholds out of range) are caught by an elaboration-time check and produce a fatal error.

Decomposition:
- Package fifo_pkg holds:
  - a ptr_width function returning $clog2(depth)+1
  - a FIFO_MODE_STD = 0 constant
  - a FIFO_MODE_FWFT = 1 constant
- One sub-module, fifo_mem: WIDTH x DEPTH register array with no reset, one synchronous write port and one asynchronous read port. The top level owns pointers, flags, mode muxing and error pulses.

Test Plan (WIDTH=16, DEPTH=4, AF_THRESH=3, AE_THRESH=1):
- Reset then idle:
  - empty=1, full=0, count=0, almost_empty=1, out_data=0.
  - r_en for 1 cycle -> underflow=1 for exactly one cycle, count stays 0.
- FWFT=0, write 0xA001..0xA004:
  - count 1,2,3,4; almost_full at count=3; full at 4.
  - 5th write 0xA005 -> overflow pulse; reads return 0xA001..0xA004, each 1 cycle after r_en; 0xA005 never appears.
- FWFT=1, single write 0xBEEF into empty FIFO:
  - next cycle empty=0 and out_data=0xBEEF with no r_en.
  - r_en -> next cycle empty=1 and out_data=0.
- Full FIFO, simultaneous w_en and r_en:
  - read returns oldest word; write rejected with overflow=1; count goes 4->3.
- Simultaneous w_en and r_en at count=2 for 10 cycles with an incrementing pattern:
  - count stays 2, data order preserved, both pointer MSBs toggle with no false full/empty.
- Reset asserted asynchronously mid-clock with count=3:
  - empty=1, count=0 immediately, out_data=0.
  - After release, a write of 0x1234 followed by a read returns 0x1234.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared constants and pointer-width helper for the sync FIFO.
// Rev 1.0
// ============================================================================
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// fifo_mem : WIDTH x DEPTH storage, one sync write port, one async read port.
// Rev 1.0
// ============================================================================
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// fifo_sync_flags : single-clock FIFO with std/FWFT read, count, almost flags
//                   and overflow/underflow pulses.               Rev 1.0
// ============================================================================
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int c_ptr_w  = ptr_width(DEPTH);
  localparam int c_addr_w = c_ptr_w - 1;
  localparam logic [c_ptr_w-1:0] c_af_thresh = c_ptr_w'(AF_THRESH);
  localparam logic [c_ptr_w-1:0] c_ae_thresh = c_ptr_w'(AE_THRESH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AF_THRESH < 1) || (AF_THRESH > DEPTH) ||
        (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1) ||
        ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT))) begin : g_bad_params
      $fatal(1, "fifo_sync_flags: illegal parameter combination");
    end
  endgenerate

  logic [c_ptr_w-1:0] w_ptr_q, w_ptr_d;
  logic [c_ptr_w-1:0] r_ptr_q, r_ptr_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               wr_accept, rd_accept;
  logic [WIDTH-1:0]   mem_rd_data;

  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[c_addr_w] != r_ptr_q[c_addr_w]) &&
                 (w_ptr_q[c_addr_w-1:0] == r_ptr_q[c_addr_w-1:0]);
  assign count        = w_ptr_q - r_ptr_q;
  assign almost_full  = (count >= c_af_thresh);
  assign almost_empty = (count <= c_ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_accept   = w_en & ~full;
    rd_accept   = r_en & ~empty;
    w_ptr_d     = wr_accept ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d     = rd_accept ? r_ptr_q + 1'b1 : r_ptr_q;
    overflow_d  = w_en & full;
    underflow_d = r_en & empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (wr_accept),
    .i_wr_addr (w_ptr_q[c_addr_w-1:0]),
    .i_wr_data (in_data),
    .i_rd_addr (r_ptr_q[c_addr_w-1:0]),
    .o_rd_data (mem_rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented directly; forced to zero so stale memory never leaks out.
      assign out_data = empty ? '0 : mem_rd_data;
    end else begin : g_std
      logic [WIDTH-1:0] out_data_q, out_data_d;

      always_comb begin
        out_data_d = rd_accept ? mem_rd_data : out_data_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_data_q <= '0;
        end else begin
          out_data_q <= out_data_d;
        end
      end

      assign out_data = out_data_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// tb_fifo_sync_flags : drives a standard-mode and an FWFT-mode FIFO in lockstep
//                      against a queue-based reference model.       Rev 1.0
// ============================================================================
module tb_fifo_sync_flags;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             w_en;
  logic             r_en;
  logic [WIDTH-1:0] in_data;

  logic [WIDTH-1:0] out_s, out_f;
  logic             full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic             full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [CW-1:0]    cnt_s, cnt_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) dut_std (
    .clk(clk), .rst(rst), .w_en(w_en), .in_data(in_data), .r_en(r_en), .out_data(out_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(cnt_s), .overflow(ovf_s), .underflow(udf_s));

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) dut_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .in_data(in_data), .r_en(r_en), .out_data(out_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f), .underflow(udf_f));

  // Reference model: contents as a queue, plus the registered std-mode output and error pulses.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out_std;
  logic             m_ovf, m_udf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_out_std = '0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
    end else begin
      automatic int  n    = m_q.size();
      automatic bit  do_r = r_en && (n > 0);
      automatic bit  do_w = w_en && (n < DEPTH);
      m_ovf = w_en && (n == DEPTH);
      m_udf = r_en && (n == 0);
      if (do_r) m_out_std = m_q.pop_front();
      if (do_w) m_q.push_back(in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic int n = m_q.size();
    automatic logic [WIDTH-1:0] head = (n > 0) ? m_q[0] : '0;
    chk("count_std",  32'(cnt_s),  32'(n));
    chk("count_fwft", 32'(cnt_f),  32'(n));
    chk("empty_std",  32'(empty_s), 32'(n == 0));
    chk("empty_fwft", 32'(empty_f), 32'(n == 0));
    chk("full_std",   32'(full_s),  32'(n == DEPTH));
    chk("full_fwft",  32'(full_f),  32'(n == DEPTH));
    chk("af_std",     32'(af_s),    32'(n >= AF));
    chk("af_fwft",    32'(af_f),    32'(n >= AF));
    chk("ae_std",     32'(ae_s),    32'(n <= AE));
    chk("ae_fwft",    32'(ae_f),    32'(n <= AE));
    chk("ovf_std",    32'(ovf_s),   32'(m_ovf));
    chk("ovf_fwft",   32'(ovf_f),   32'(m_ovf));
    chk("udf_std",    32'(udf_s),   32'(m_udf));
    chk("udf_fwft",   32'(udf_f),   32'(m_udf));
    chk("out_std",    32'(out_s),   32'(m_out_std));
    chk("out_fwft",   32'(out_f),   32'(head));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; in_data = '0;
    repeat (2) step();
    rst = 1'b1;
    step();

    // Reset then idle
    chk("lit_rst_empty", 32'(empty_s), 32'd1);
    chk("lit_rst_full",  32'(full_s),  32'd0);
    chk("lit_rst_count", 32'(cnt_s),   32'd0);
    chk("lit_rst_ae",    32'(ae_s),    32'd1);
    chk("lit_rst_out",   32'(out_s),   32'd0);
    chk("lit_rst_outf",  32'(out_f),   32'd0);

    r_en = 1'b1; step(); r_en = 1'b0;
    chk("lit_udf_pulse", 32'(udf_s), 32'd1);
    chk("lit_udf_cnt",   32'(cnt_s), 32'd0);
    step();
    chk("lit_udf_clear", 32'(udf_s), 32'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; in_data = 16'hA001 + 16'(i);
      step();
      chk("lit_fill_cnt", 32'(cnt_s), 32'(i + 1));
      chk("lit_fill_af",  32'(af_s),  32'(i + 1 >= 3));
      chk("lit_fill_full", 32'(full_s), 32'(i + 1 == 4));
    end
    in_data = 16'hA005; step(); w_en = 1'b0;
    chk("lit_ovf_pulse", 32'(ovf_s), 32'd1);
    chk("lit_ovf_cnt",   32'(cnt_s), 32'd4);
    step();
    chk("lit_ovf_clear", 32'(ovf_s), 32'd0);

    // Full with simultaneous read and write
    w_en = 1'b1; r_en = 1'b1; in_data = 16'hA0FF;
    step();
    w_en = 1'b0; r_en = 1'b0;
    chk("lit_fullrw_out", 32'(out_s), 32'hA001);
    chk("lit_fullrw_ovf", 32'(ovf_s), 32'd1);
    chk("lit_fullrw_cnt", 32'(cnt_s), 32'd3);
    for (int i = 0; i < 3; i++) begin
      r_en = 1'b1; step(); r_en = 1'b0;
      chk("lit_drain_out", 32'(out_s), 32'(16'hA002 + 16'(i)));
    end
    chk("lit_drain_empty", 32'(empty_s), 32'd1);

    // FWFT single word fall-through
    w_en = 1'b1; in_data = 16'hBEEF; step(); w_en = 1'b0;
    chk("lit_fwft_empty", 32'(empty_f), 32'd0);
    chk("lit_fwft_out",   32'(out_f),   32'hBEEF);
    r_en = 1'b1; step(); r_en = 1'b0;
    chk("lit_fwft_pop_empty", 32'(empty_f), 32'd1);
    chk("lit_fwft_pop_out",   32'(out_f),   32'd0);

    // Streaming at count=2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      w_en = 1'b1; in_data = 16'h1000 + 16'(i); step();
    end
    for (int i = 0; i < 10; i++) begin
      w_en = 1'b1; r_en = 1'b1; in_data = 16'h1002 + 16'(i);
      step();
      chk("lit_stream_cnt", 32'(cnt_s), 32'd2);
      chk("lit_stream_out", 32'(out_s), 32'(16'h1000 + 16'(i)));
      chk("lit_stream_full", 32'(full_s), 32'd0);
      chk("lit_stream_empty", 32'(empty_s), 32'd0);
    end
    w_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lit_stream_tail", 32'(out_s), 32'(16'h100A + 16'(i)));
    end
    r_en = 1'b0;

    // Asynchronous reset mid-cycle with count=3
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; in_data = 16'h2000 + 16'(i); step();
    end
    w_en = 1'b0;
    chk("lit_pre_rst_cnt", 32'(cnt_s), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("lit_async_empty", 32'(empty_s), 32'd1);
    chk("lit_async_cnt",   32'(cnt_s),   32'd0);
    chk("lit_async_out",   32'(out_s),   32'd0);
    chk("lit_async_outf",  32'(out_f),   32'd0);
    step(); rst = 1'b1; step();
    w_en = 1'b1; in_data = 16'h1234; step(); w_en = 1'b0;
    chk("lit_post_rst_fwft", 32'(out_f), 32'h1234);
    r_en = 1'b1; step(); r_en = 1'b0;
    chk("lit_post_rst_std", 32'(out_s), 32'h1234);

    // Randomized phases biased toward filling then draining, with occasional resets
    for (int i = 0; i < 600; i++) begin
      automatic int phase = (i / 40) % 3;
      w_en    = ($urandom_range(0, 99) < (phase == 0 ? 80 : (phase == 1 ? 20 : 50)));
      r_en    = ($urandom_range(0, 99) < (phase == 0 ? 20 : (phase == 1 ? 80 : 50)));
      in_data = 16'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end
    w_en = 1'b0; r_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
